// File: rtl/writeback_unit_if.sv
// Handshake and result bus between decode, the ALU/load units and the writeback unit.
// master = the surrounding pipeline, slave = writeback_unit.
interface writeback_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  localparam int NREGS = 2 ** ADDR_W;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dest;
  logic              issue_stall;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [NREGS-1:0]  busy;
  logic [ADDR_W-1:0] fwd_addr_1;
  logic [ADDR_W-1:0] fwd_addr_2;
  logic              fwd_hit_1;
  logic              fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_1;
  logic [DATA_W-1:0] fwd_data_2;

  modport master (
    output issue_valid, issue_dest, alu_valid, alu_dest, alu_data,
           mem_valid, mem_dest, mem_data, fwd_addr_1, fwd_addr_2,
    input  issue_stall, alu_ready, mem_ready, rf_wr_en, rf_wr, rf_wr_data,
           busy, fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2
  );

  modport slave (
    input  issue_valid, issue_dest, alu_valid, alu_dest, alu_data,
           mem_valid, mem_dest, mem_data, fwd_addr_1, fwd_addr_2,
    output issue_stall, alu_ready, mem_ready, rf_wr_en, rf_wr, rf_wr_data,
           busy, fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2
  );
endinterface

// File: rtl/writeback_unit.sv
// GPR write-port producer: per-source result queues, round-robin arbitration onto one
// registered write port, pending-write scoreboard and same-cycle bypass.
module writeback_queue #(
  parameter int W     = 20,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_q, rd_q;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign dout_o  = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + {{PW{1'b0}}, 1'b1};
      if (pop_i)  rd_q <= rd_q + {{PW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[PW-1:0]] <= din_i;
  end
endmodule

module writeback_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int Q_DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  writeback_unit_if.slave  bus
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam int NSRC  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;
  localparam int REQ_W = $bits(wb_req_t);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  logic [NSRC-1:0]            src_valid, q_push, q_pop, q_empty, q_full;
  logic [NSRC-1:0][REQ_W-1:0] q_din, q_dout;

  src_e              gnt, last_grant_q;
  wb_req_t           head;
  logic              any_pend, tie, wr_fire, issue_set;
  logic              rf_wr_en_q;
  logic [ADDR_W-1:0] rf_wr_q;
  logic [DATA_W-1:0] rf_wr_data_q;
  logic [NREGS-1:0]  busy_q, busy_d;

  assign src_valid      = {bus.mem_valid, bus.alu_valid};
  assign q_din[SRC_ALU] = {bus.alu_dest, bus.alu_data};
  assign q_din[SRC_MEM] = {bus.mem_dest, bus.mem_data};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    assign q_push[s] = src_valid[s] && !q_full[s];
    assign q_pop[s]  = any_pend && (int'(gnt) == s);

    writeback_queue #(.W(REQ_W), .DEPTH(Q_DEPTH)) u_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (q_push[s]),
      .din_i   (q_din[s]),
      .pop_i   (q_pop[s]),
      .dout_o  (q_dout[s]),
      .empty_o (q_empty[s]),
      .full_o  (q_full[s])
    );
  end

  assign bus.alu_ready = !q_full[SRC_ALU];
  assign bus.mem_ready = !q_full[SRC_MEM];

  assign any_pend = |(~q_empty);
  assign tie      = &(~q_empty);

  // last_grant only moves on a tie, so a lone source never steals the next tie's turn.
  always_comb begin
    gnt = SRC_ALU;
    if (tie)                   gnt = (last_grant_q == SRC_MEM) ? SRC_ALU : SRC_MEM;
    else if (!q_empty[SRC_MEM]) gnt = SRC_MEM;
  end

  assign head    = wb_req_t'(q_dout[gnt]);
  assign wr_fire = any_pend && (head.dest != '0);

  assign bus.issue_stall = bus.issue_valid && busy_q[bus.issue_dest] && (bus.issue_dest != '0);
  assign issue_set       = bus.issue_valid && !bus.issue_stall && (bus.issue_dest != '0);

  // Set is applied after clear so a same-edge reissue keeps the register pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_fire)   busy_d[head.dest]       = 1'b0;
    if (issue_set) busy_d[bus.issue_dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_q      <= '0;
      rf_wr_data_q <= '0;
      busy_q       <= '0;
      last_grant_q <= SRC_MEM;
    end else begin
      rf_wr_en_q <= wr_fire;
      if (wr_fire) begin
        rf_wr_q      <= head.dest;
        rf_wr_data_q <= head.data;
      end
      if (tie) last_grant_q <= gnt;
      busy_q <= busy_d;
    end
  end

  assign bus.rf_wr_en   = rf_wr_en_q;
  assign bus.rf_wr      = rf_wr_q;
  assign bus.rf_wr_data = rf_wr_data_q;
  assign bus.busy       = busy_q;

  // The GPR file returns the pre-write value on a write edge, so decode takes these instead.
  assign bus.fwd_hit_1  = rf_wr_en_q && (rf_wr_q == bus.fwd_addr_1) && (rf_wr_q != '0);
  assign bus.fwd_hit_2  = rf_wr_en_q && (rf_wr_q == bus.fwd_addr_2) && (rf_wr_q != '0);
  assign bus.fwd_data_1 = bus.fwd_hit_1 ? rf_wr_data_q : '0;
  assign bus.fwd_data_2 = bus.fwd_hit_2 ? rf_wr_data_q : '0;
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected writes are queued at issue time and a
// negedge monitor pops and compares every rf_wr_en cycle.
module tb_writeback_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  writeback_unit_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  writeback_unit #(.DATA_W(16), .ADDR_W(4), .Q_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dest;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [3:0] d, input logic [15:0] v);
    exp_t e;
    e.dest = d;
    e.data = v;
    exp_q.push_back(e);
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.rf_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {12'h0, bus.rf_wr, bus.rf_wr_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_dest", 32'(bus.rf_wr), 32'(e.dest));
        chk("wr_data", 32'(bus.rf_wr_data), 32'(e.data));
      end
    end
  end

  task automatic alu_send(input logic [3:0] d, input logic [15:0] v);
    int n = 0;
    bus.alu_valid = 1'b1; bus.alu_dest = d; bus.alu_data = v;
    @(negedge clk);
    while (!bus.alu_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("alu_handshake_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    bus.alu_valid = 1'b0;
  endtask

  task automatic mem_send(input logic [3:0] d, input logic [15:0] v);
    int n = 0;
    bus.mem_valid = 1'b1; bus.mem_dest = d; bus.mem_data = v;
    @(negedge clk);
    while (!bus.mem_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("mem_handshake_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    if (n >= 50) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rf_wr_en"}, 32'(bus.rf_wr_en), 32'd0);
    chk({tag, "_rf_wr"}, 32'(bus.rf_wr), 32'd0);
    chk({tag, "_rf_wr_data"}, 32'(bus.rf_wr_data), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_alu_ready"}, 32'(bus.alu_ready), 32'd1);
    chk({tag, "_mem_ready"}, 32'(bus.mem_ready), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_dest = '0;
    bus.alu_valid = 1'b0; bus.alu_dest = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_dest = '0; bus.mem_data = '0;
    bus.fwd_addr_1 = '0; bus.fwd_addr_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] d, input logic exp_stall, input string tag);
    bus.issue_valid = 1'b1; bus.issue_dest = d;
    #1;
    chk({tag, "_stall"}, 32'(bus.issue_stall), 32'(exp_stall));
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_alu_full, saw_mem_full;

    do_reset();

    // 1: single ALU result, two-edge latency, scoreboard clear on the write edge
    issue(4'd5, 1'b0, "t1_issue");
    chk("t1_busy_set", 32'(bus.busy), 32'h0020);
    expect_wr(4'd5, 16'h1234);
    alu_send(4'd5, 16'h1234);
    chk("t1_no_write_yet", 32'(bus.rf_wr_en), 32'd0);
    @(posedge clk); #1;
    chk("t1_wr_en", 32'(bus.rf_wr_en), 32'd1);
    chk("t1_busy_clr", 32'(bus.busy), 32'h0000);
    @(posedge clk); #1;
    chk("t1_single_pulse", 32'(bus.rf_wr_en), 32'd0);

    // 2: simultaneous arrivals; first tie ALU, second tie MEM
    do_reset();
    expect_wr(4'd3, 16'hAAAA);
    expect_wr(4'd7, 16'h5555);
    fork
      alu_send(4'd3, 16'hAAAA);
      mem_send(4'd7, 16'h5555);
    join
    wait_drain();
    expect_wr(4'd7, 16'h6666);
    expect_wr(4'd3, 16'hBBBB);
    fork
      alu_send(4'd3, 16'hBBBB);
      mem_send(4'd7, 16'h6666);
    join
    wait_drain();

    // 3: sustained traffic from both sources fills the queues; grants alternate
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_wr(4'(1 + i), 16'hA000 + 16'(i));
      expect_wr(4'(8 + i), 16'hB000 + 16'(i));
    end
    saw_alu_full = 1'b0;
    saw_mem_full = 1'b0;
    fork
      for (int i = 0; i < 4; i++) alu_send(4'(1 + i), 16'hA000 + 16'(i));
      for (int j = 0; j < 4; j++) mem_send(4'(8 + j), 16'hB000 + 16'(j));
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (!bus.alu_ready) saw_alu_full = 1'b1;
        if (!bus.mem_ready) saw_mem_full = 1'b1;
      end
    join
    wait_drain();
    chk("t3_alu_ready_dropped", 32'(saw_alu_full), 32'd1);
    chk("t3_mem_ready_dropped", 32'(saw_mem_full), 32'd1);

    // 5: stall on a pending register, clear on writeback, set-wins collision
    issue(4'd9, 1'b0, "t5_first");
    chk("t5_busy_set", 32'(bus.busy), 32'h0200);
    issue(4'd9, 1'b1, "t5_second");
    chk("t5_busy_stalled", 32'(bus.busy), 32'h0200);
    expect_wr(4'd9, 16'h0909);
    alu_send(4'd9, 16'h0909);
    chk("t5_busy_before_wr", 32'(bus.busy), 32'h0200);
    @(posedge clk); #1;
    chk("t5_busy_cleared", 32'(bus.busy), 32'h0000);
    expect_wr(4'd9, 16'h0A0A);
    alu_send(4'd9, 16'h0A0A);
    issue(4'd9, 1'b0, "t5_collide");
    chk("t5_collide_wr_en", 32'(bus.rf_wr_en), 32'd1);
    chk("t5_set_wins", 32'(bus.busy), 32'h0200);
    wait_drain();

    // 4: dest-0 result is dropped without a write; write port holds its last value
    alu_send(4'd0, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("t4_busy_unchanged", 32'(bus.busy), 32'h0200);
    chk("t4_rf_wr_held", 32'(bus.rf_wr), 32'd9);
    chk("t4_rf_data_held", 32'(bus.rf_wr_data), 32'h0A0A);
    chk("t4_drained_ready", 32'(bus.alu_ready), 32'd1);

    // 6: bypass during the write cycle
    bus.fwd_addr_1 = 4'd5;
    bus.fwd_addr_2 = 4'd6;
    expect_wr(4'd5, 16'h00C3);
    alu_send(4'd5, 16'h00C3);
    @(posedge clk); #1;
    chk("t6_hit_1", 32'(bus.fwd_hit_1), 32'd1);
    chk("t6_data_1", 32'(bus.fwd_data_1), 32'h00C3);
    chk("t6_hit_2", 32'(bus.fwd_hit_2), 32'd0);
    chk("t6_data_2", 32'(bus.fwd_data_2), 32'd0);
    @(posedge clk); #1;
    chk("t6_hit_1_after", 32'(bus.fwd_hit_1), 32'd0);
    chk("t6_data_1_after", 32'(bus.fwd_data_1), 32'd0);

    // 7: asynchronous reset mid-burst with the ALU queue full
    do_reset();
    issue(4'd1, 1'b0, "t7_issue");
    expect_wr(4'd4, 16'h4444);
    expect_wr(4'd8, 16'h8888);
    bus.alu_valid = 1'b1; bus.alu_dest = 4'd4; bus.alu_data = 16'h4444;
    bus.mem_valid = 1'b1; bus.mem_dest = 4'd8; bus.mem_data = 16'h8888;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t7_alu_full", 32'(bus.alu_ready), 32'd0);
    chk("t7_wr_before_rst", 32'(bus.rf_wr_en), 32'd1);
    chk("t7_busy_before_rst", 32'(bus.busy), 32'h0002);
    #1;
    rst_n = 1'b0;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    check_reset_state("t7_async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t7_no_late_write", 32'(bus.rf_wr_en), 32'd0);
    chk("t7_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
